ifu_idu_skid_buffer: RTL and testbench

- Elastic fetch-to-decode buffer between the IFU (fetch stage) and the IDU (decode stage).
- Captures {pc, inst, fault} from the IFU with a valid/ready handshake and presents them to the IDU one cycle later.
- Decouples IFU stalls from IDU back-pressure.
- Supports a single-cycle flush on control-flow redirect (branch, jump, trap, mret).

---
 rtl/ifu_idu_skid_buffer_pkg.sv | 19 +
 rtl/ifu_idu_skid_buffer_fifo_mem.sv | 33 +++
 rtl/ifu_idu_skid_buffer.sv | 114 +++++++++++
 tb/tb_ifu_idu_skid_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_idu_skid_buffer_pkg.sv
// Shared fetch-path definitions: datapath width, the fetch packet layout
// carried from IFU to IDU, and the architectural reset PC.
package ifu_idu_skid_buffer_pkg;

  localparam int unsigned XLEN = 32;

  // Reset vector; the PC unit starts fetching from here.
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  // One fetched instruction as it travels from fetch to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            fault;
  } fetch_pkt_t;

  localparam int unsigned PKT_W = $bits(fetch_pkt_t);

endpackage : ifu_idu_skid_buffer_pkg

// File: rtl/ifu_idu_skid_buffer_fifo_mem.sv
// Small register array for the skid buffer: one write port, one
// asynchronous read port. Entries are cleared on reset so the read port
// shows zeros until the first write.
module ifu_idu_skid_buffer_fifo_mem #(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage write: only accepted pushes land in the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : ifu_idu_skid_buffer_fifo_mem

// File: rtl/ifu_idu_skid_buffer.sv
// Elastic fetch-to-decode buffer. Holds up to DEPTH fetch packets between
// the IFU and the IDU, with registered occupancy so that in_ready never
// depends on out_ready, and no bypass so out_* never depends on in_*.
// A flush (control-flow redirect) empties the buffer in one cycle.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both 1 on that side (push = in_valid & in_ready, pop = out_valid &
// out_ready). The producer must hold its payload stable while valid=1 and
// ready=0; the buffer holds out_* stable while out_valid=1 and out_ready=0.
module ifu_idu_skid_buffer
  import ifu_idu_skid_buffer_pkg::*;
#(
  parameter int unsigned XLEN  = ifu_idu_skid_buffer_pkg::XLEN,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_inst,
  input  logic             in_fault,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  output logic             out_fault,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned W  = 2 * XLEN + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

  logic             push;
  logic             pop;
  logic [W-1:0]     wr_data;
  logic [W-1:0]     rd_data;

  // Ready comes only from registered occupancy and flush; a pop in the
  // same cycle does not free a slot until the next cycle.
  assign in_ready  = ~rst & ~flush & (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign wr_data = {in_pc, in_inst, in_fault};

  ifu_idu_skid_buffer_fifo_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Head entry goes straight from storage to the decode stage.
  assign out_pc    = rd_data[W-1 -: XLEN];
  assign out_inst  = rd_data[XLEN:1];
  assign out_fault = rd_data[0];

  assign count = count_q;

  // Next-state for occupancy and pointers; flush overrides any handshake
  // (push is already blocked by in_ready, a concurrent pop is ignored).
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule : ifu_idu_skid_buffer

// File: tb/tb_ifu_idu_skid_buffer.sv
// Bench for the fetch-to-decode skid buffer. A queue of in-flight packets
// is the reference: packets join the tail when the IFU side hands over,
// leave the head when the IDU side takes one, and vanish on flush/reset.
module tb_ifu_idu_skid_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int W     = 2 * XLEN + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_inst;
  logic             in_fault;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_inst;
  logic             out_fault;
  logic             flush;
  logic [CNT_W-1:0] count;

  int total;
  int bad;
  logic last_push;
  logic [W-1:0] exp_q[$];

  ifu_idu_skid_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_fault  (in_fault),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_fault (out_fault),
    .flush     (flush),
    .count     (count)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                       input logic flt, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_fault  = flt;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock cycle: compare outputs against the queue mid-cycle, then
  // advance the queue by what the handshake rules say happens at the edge.
  task automatic step();
    logic exp_ready;
    logic do_push;
    logic do_pop;
    @(negedge clk);
    exp_ready = !flush && (exp_q.size() < DEPTH);
    check("in_ready", W'(in_ready), W'(exp_ready));
    check("count", W'(count), W'(exp_q.size()));
    check("out_valid", W'(out_valid), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_pkt", {out_pc, out_inst, out_fault}, exp_q[0]);
    end
    do_push = in_valid && exp_ready;
    do_pop  = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_pc, in_inst, in_fault});
    end
    last_push = do_push;
    #1;
  endtask

  // Keep offering the current packet until it is taken (bounded).
  task automatic push_until_taken(input logic ordy);
    int tries;
    tries = 0;
    last_push = 1'b0;
    while (!last_push && tries < 10) begin
      out_ready = ordy;
      step();
      tries++;
    end
    check("accept_timeout", W'(last_push), W'(1));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_push = 1'b0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset then idle
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", W'(in_ready), W'(0));
      check("rst_count", W'(count), W'(0));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_pkt", {out_pc, out_inst, out_fault}, '0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    step();

    // Streaming with out_ready held high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h8000_0000 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b1, 1'b0);
      step();
      check("stream_accept", W'(last_push), W'(1));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    // Back-pressure: third packet is held by the IFU
    drive(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0004, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0008, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step();
    check("bp_held", W'(last_push), W'(0));
    push_until_taken(1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    // Full plus simultaneous pop: push rejected, count drops to 1
    drive(1'b1, 32'h8000_0010, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0014, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0018, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    step();
    check("full_pop_rejected", W'(last_push), W'(0));
    drive(1'b0, 32'h8000_0018, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step();

    // Flush with a concurrent push attempt
    drive(1'b1, 32'h8000_0020, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0100, 32'h0000_0013, 1'b0, 1'b1, 1'b1);
    step();
    check("flush_no_push", W'(last_push), W'(0));
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h8000_0200, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    // Fault and pointer wrap, occupancy bouncing between 1 and 2
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h8000_0300 + 32'(4 * i), (i == 2) ? 32'hDEAD_BEEF : 32'h0000_0013,
            (i == 2), 1'b0, 1'b0);
      push_until_taken((i % 2) == 1);
      if (out_valid) begin
        check("fault_tag", W'(out_fault), W'(out_inst == 32'hDEAD_BEEF));
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();

    // Randomized traffic with an IFU that holds its packet until accepted
    in_valid = 1'b0;
    last_push = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_push) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc    = $urandom;
        in_inst  = $urandom;
        in_fault = ($urandom_range(0, 7) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end

    // Reset asserted mid-operation acts immediately
    drive(1'b1, 32'h8000_0400, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    check("midrst_count", W'(count), W'(0));
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(0));
    check("midrst_out_pkt", {out_pc, out_inst, out_fault}, '0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 32'h8000_0500, 32'h0000_0013, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ifu_idu_skid_buffer
